// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a ready/valid byte input and a registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       busy
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
`ifdef UART_TX_PARITY_EN
    logic            par;
`endif

    logic bit_end;
    assign bit_end = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            uart_txd <= 1'b1;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    // ready comes up one edge after reset release, never combinationally
                    if (!tx_ready) begin
                        tx_ready <= 1'b1;
                    end else if (tx_valid) begin
                        state    <= START;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        uart_txd <= 1'b0;
                        cnt      <= RELOAD;
                        shreg    <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par      <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        uart_txd <= shreg[0];
                        idx      <= '0;
                        cnt      <= RELOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= RELOAD;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_txd <= par;
`else
                            state    <= STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            // shreg[0] is the bit on the line; next bit moves into place
                            idx      <= idx + 3'd1;
                            uart_txd <= shreg[1];
                            shreg    <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                        cnt      <= RELOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic in this single clock domain.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tx_data  input  8  byte to transmit; sampled only on handshake.
REQ-005 SHALL have port tx_valid  input  1  upstream byte available; connects to the skid_buffer rd_valid.
REQ-006 SHALL have port tx_ready  output  1  block can accept a byte; drives the skid_buffer rd_ready.
REQ-007 SHALL have port uart_txd  output  1  serial line, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is on the line.

Function
REQ-009 SHALL complete a handshake on a rising clk edge where tx_valid=1 and tx_ready=1; the block captures tx_data at that edge.
REQ-010 SHALL implement the states IDLE, START, DATA, PARITY (REQ-027 only), STOP.
REQ-011 SHALL drive tx_ready=1 only in IDLE; tx_ready SHALL be registered and SHALL go to 0 on the handshake edge.
REQ-012 SHALL move IDLE->START on handshake; uart_txd SHALL be 0 from that edge (registered output, no combinational path from inputs).
REQ-013 SHALL hold each bit for exactly BAUD_DIV clocks, timed by a down-counter reloaded to BAUD_DIV-1 at every bit boundary; counter width is clog2(BAUD_DIV).
REQ-014 SHALL send the data bits LSB first in DATA, using a 3-bit index that runs 0..7; after index 7 it SHALL go to STOP, or to PARITY when configured.
REQ-015 SHALL drive uart_txd=1 in STOP for BAUD_DIV clocks, then enter IDLE with tx_ready=1 on the same edge.
REQ-016 SHALL give a frame period of 10*BAUD_DIV clocks, 11*BAUD_DIV with parity, plus exactly one IDLE clock between back-to-back frames when tx_valid is held high.
REQ-017 SHALL drive busy=1 in START, DATA, PARITY and STOP, and 0 in IDLE and in reset.
REQ-018 SHALL ignore tx_valid and tx_data while tx_ready=0; a changing tx_data mid-frame SHALL not alter the frame on the line.
REQ-019 SHALL drive uart_txd=1 in IDLE regardless of tx_valid.

Reset
REQ-020 SHALL, while rst=1, force state=IDLE, uart_txd=1, tx_ready=0, busy=0, and the counter and bit index to 0, asynchronously.
REQ-021 SHALL raise tx_ready on the first clk edge after rst deasserts.
REQ-022 SHALL, on reset mid-frame, abort the frame with uart_txd=1 immediately and not resume it; the aborted byte is lost.

Configuration
REQ-023 SHALL use the macro UART_TX_PARITY_EN.
REQ-024 SHALL, with UART_TX_PARITY_EN defined, insert one even-parity bit (XOR of the 8 data bits) between DATA and STOP, lasting BAUD_DIV clocks.
REQ-025 SHALL, without UART_TX_PARITY_EN, contain no PARITY state or parity logic; the frame is 8N1.
REQ-026 SHALL keep all ports identical in both builds.
REQ-027 SHALL keep the PARITY state reachable only when UART_TX_PARITY_EN is defined.

Verification (BAUD_DIV=4 unless noted)
REQ-028 SHALL verify: reset release, no tx_valid -> tx_ready=1 one edge later; uart_txd=1 and busy=0 held for 100 clocks.
REQ-029 SHALL verify: send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; tx_ready=0 for 40 clocks, then 1.
REQ-030 SHALL verify: tx_valid held high with 0x00 then 0xFF -> two frames spaced 41 clocks start-to-start; bytes decoded in order.
REQ-031 SHALL verify: rst asserted 13 clocks into a frame of 0x3C -> uart_txd=1 in the same cycle; after release, next byte 0x55 is sent intact.
REQ-032 SHALL verify: UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 and a 44-clock frame; send 0x03 -> parity bit 0.
REQ-033 SHALL verify: fifo_sync + skid_buffer + uart_tx chain at BAUD_DIV=2 with 256 random bytes -> line monitor decodes all 256 in order.
